// File: rtl/adder_tree_pipe.sv
// Fully pipelined binary adder tree summing 2^LOG2_INPUTS operands, with valid/ready back-pressure.
// Define ADDER_TREE_ACCUM_EN to add a stage that accumulates acc_len+1 tree results per output.
module adder_tree_pipe #(
    parameter int WIDTH       = 64,
    parameter int LOG2_INPUTS = 3,
    parameter int SIGNED      = 0,
    parameter int ACC_BITS    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [(1<<LOG2_INPUTS)*WIDTH-1:0]     in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH+LOG2_INPUTS+ACC_BITS-1:0] out_sum,
    input  logic [ACC_BITS-1:0]                   acc_len
);

    localparam int N      = 1 << LOG2_INPUTS;
    localparam int TREE_W = WIDTH + LOG2_INPUTS;
    localparam int OUT_W  = TREE_W + ACC_BITS;
    localparam bit SGN    = (SIGNED != 0);

    // One enable for every stage: the whole pipe advances unless the output is stalled.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar lv = 0; lv <= LOG2_INPUTS; lv++) begin : g_lvl
        localparam int W   = WIDTH + lv;
        localparam int CNT = N >> lv;

        logic         v;
        logic [W-1:0] d [CNT];

        if (lv == 0) begin : g_in
            // NOTE: the operand registers are reset too, so out_sum reads 0 during reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    for (int i = 0; i < CNT; i++) d[i] <= '0;
                end else if (en) begin
                    v <= in_valid;
                    for (int i = 0; i < CNT; i++) d[i] <= in_data[i*WIDTH +: WIDTH];
                end
            end
        end else begin : g_add
            localparam int PW = W - 1;

            // Each level widens by one bit (sign or zero extension) so pair sums never overflow.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= 1'b0;
                    for (int i = 0; i < CNT; i++) d[i] <= '0;
                end else if (en) begin
                    v <= g_lvl[lv-1].v;
                    for (int i = 0; i < CNT; i++)
                        d[i] <= {SGN & g_lvl[lv-1].d[2*i][PW-1],   g_lvl[lv-1].d[2*i]}
                              + {SGN & g_lvl[lv-1].d[2*i+1][PW-1], g_lvl[lv-1].d[2*i+1]};
                end
            end
        end
    end

    logic              tree_vld;
    logic [TREE_W-1:0] tree_sum;
    logic [OUT_W-1:0]  tree_ext;

    assign tree_vld = g_lvl[LOG2_INPUTS].v;
    assign tree_sum = g_lvl[LOG2_INPUTS].d[0];
    assign tree_ext = {{ACC_BITS{SGN & tree_sum[TREE_W-1]}}, tree_sum};

`ifdef ADDER_TREE_ACCUM_EN
    logic [OUT_W-1:0]    acc_q;
    logic [OUT_W-1:0]    acc_sum;
    logic [OUT_W-1:0]    sum_q;
    logic [ACC_BITS-1:0] cnt_q;
    logic [ACC_BITS-1:0] len_q;
    logic                vld_q;
    logic                last_beat;

    // acc_q is always zero at the start of a group, so the first beat simply loads.
    assign acc_sum   = acc_q + tree_ext;
    assign last_beat = (cnt_q == '0) ? (acc_len == '0) : (cnt_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            vld_q <= 1'b0;
        end else if (en) begin
            // NOTE: later non-blocking assignments in the same block override this default.
            vld_q <= 1'b0;
            if (tree_vld) begin
                if (cnt_q == '0) len_q <= acc_len;
                if (last_beat) begin
                    vld_q <= 1'b1;
                    sum_q <= acc_sum;
                    acc_q <= '0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign out_valid = vld_q;
    assign out_sum   = sum_q;
`else
    logic unused_acc_len;
    assign unused_acc_len = ^acc_len;

    assign out_valid = tree_vld;
    assign out_sum   = tree_ext;
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed vector table plus stream, bubble, reset
// and (with ADDER_TREE_ACCUM_EN) group-accumulation sequences.
module tb_adder_tree_pipe;

    localparam int WIDTH    = 64;
    localparam int LOG2     = 3;
    localparam int N        = 8;
    localparam int ACC_BITS = 8;
    localparam int OUT_W    = WIDTH + LOG2 + ACC_BITS;
    localparam int S_W      = 8;
    localparam int S_OUT_W  = S_W + LOG2 + ACC_BITS;
`ifdef ADDER_TREE_ACCUM_EN
    localparam int LAT = LOG2 + 2;
`else
    localparam int LAT = LOG2 + 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid, in_ready, out_valid, out_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic [OUT_W-1:0]     out_sum;
    logic [ACC_BITS-1:0]  acc_len;

    logic                 s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [N*S_W-1:0]     s_in_data;
    logic [S_OUT_W-1:0]   s_out_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adder_tree_pipe #(.WIDTH(WIDTH), .LOG2_INPUTS(LOG2), .SIGNED(0), .ACC_BITS(ACC_BITS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .acc_len(acc_len)
    );

    adder_tree_pipe #(.WIDTH(S_W), .LOG2_INPUTS(LOG2), .SIGNED(1), .ACC_BITS(ACC_BITS)) u_sdut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum),
        .acc_len(acc_len)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OUT_W-1:0] model_sum(input logic [N*WIDTH-1:0] d);
        logic [OUT_W-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s += OUT_W'(d[k*WIDTH +: WIDTH]);
        return s;
    endfunction

    // Scoreboard / protocol monitor, sampled mid-cycle
    logic [OUT_W-1:0] exp_q[$];
    bit               mon_en = 1'b0;
    int               delivered = 0;
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] held;

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (stall_prev) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_sum", out_sum, held);
            end
            check("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) exp_q.push_back(model_sum(in_data));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_output got=%0h want=none", out_sum);
                end else begin
                    check("stream_sum", out_sum, exp_q.pop_front());
                    delivered++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = out_sum;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_and_wait(input string name, input logic [N*WIDTH-1:0] data,
                                 input logic [OUT_W-1:0] want);
        int lat;
        in_data   = data;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_valid"}, out_valid, 1);
        check({name, "_latency"}, lat, LAT);
        check({name, "_sum"}, out_sum, want);
        step();
        check({name, "_drained"}, out_valid, 0);
    endtask

    task automatic s_send(input string name, input logic [N*S_W-1:0] data,
                          input logic [S_OUT_W-1:0] want);
        int lat;
        s_in_data  = data;
        s_in_valid = 1'b1;
        #1;
        step();
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_valid"}, s_out_valid, 1);
        check({name, "_latency"}, lat, LAT);
        check({name, "_sum"}, s_out_sum, want);
        step();
    endtask

    typedef struct {
        string              name;
        logic [N*WIDTH-1:0] data;
        logic [OUT_W-1:0]   want;
    } vec_t;

    typedef struct {
        string              name;
        logic [N*S_W-1:0]   data;
        logic [S_OUT_W-1:0] want;
    } svec_t;

    vec_t               tbl[6];
    svec_t              stbl[4];
    logic [N*WIDTH-1:0] svec[20];
    logic [N*WIDTH-1:0] ramp, ones, vec10;
    logic               ov[0:15];
    logic [OUT_W-1:0]   os[0:15];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int  sent, cyc, lat, early;
        bit  fire;

        ramp  = {64'd8, 64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
        ones  = {8{64'd1}};
        vec10 = {64'd0, 64'd0, 64'd0, 64'd0, 64'd4, 64'd3, 64'd2, 64'd1};

        tbl[0] = '{"all_max",     {8{64'hFFFF_FFFF_FFFF_FFFF}}, 75'h7_FFFF_FFFF_FFFF_FFF8};
        tbl[1] = '{"zeros",       '0,                           75'd0};
        tbl[2] = '{"ramp",        ramp,                         75'd36};
        tbl[3] = '{"max_plus_1s", {{7{64'd1}}, 64'hFFFF_FFFF_FFFF_FFFF}, 75'h1_0000_0000_0000_0006};
        tbl[4] = '{"msb_alt",     {4{64'h8000_0000_0000_0000, 64'h0}},  75'h2_0000_0000_0000_0000};
        tbl[5] = '{"ones",        ones,                         75'd8};

        stbl[0] = '{"s_all_min", {8{8'h80}},             19'h7FC00};
        stbl[1] = '{"s_mixed",   64'h04F6_0200_FF07_FD05, 19'd4};
        stbl[2] = '{"s_all_max", {8{8'h7F}},             19'd1016};
        stbl[3] = '{"s_all_m1",  {8{8'hFF}},             19'h7FFF8};

        for (int i = 0; i < 20; i++)
            for (int k = 0; k < N; k++)
                svec[i][k*WIDTH +: WIDTH] = {32'hFFFF_0000 + 32'(i), 32'(k*7 + i)};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; acc_len = '0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_s_out_valid", s_out_valid, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        mon_en = 1'b1;
        for (int i = 0; i < 6; i++) send_and_wait(tbl[i].name, tbl[i].data, tbl[i].want);
        for (int i = 0; i < 4; i++) s_send(stbl[i].name, stbl[i].data, stbl[i].want);

        // Bubble: in_valid 1,0,1 with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= LAT + 3; i++) begin
            case (i)
                1:       begin in_valid = 1'b1; in_data = ones; end
                2:       begin in_valid = 1'b0; in_data = {8{64'd99}}; end
                3:       begin in_valid = 1'b1; in_data = ramp; end
                default: in_valid = 1'b0;
            endcase
            step();
            ov[i] = out_valid;
            os[i] = out_sum;
        end
        check("bubble_before", ov[LAT-1], 0);
        check("bubble_v0", ov[LAT], 1);
        check("bubble_v1", ov[LAT+1], 0);
        check("bubble_v2", ov[LAT+2], 1);
        check("bubble_sum0", os[LAT], 8);
        check("bubble_sum2", os[LAT+2], 36);

        // Streaming 20 vectors with out_ready toggling 1,0,1,0...
        exp_q.delete();
        delivered = 0;
        sent = 0;
        cyc  = 0;
        while (sent < 20 && cyc < 200) begin
            in_valid  = 1'b1;
            in_data   = svec[sent];
            out_ready = (cyc % 2 == 0);
            #1;
            fire = in_ready;
            step();
            cyc++;
            if (fire) sent++;
        end
        in_valid = 1'b0;
        while (delivered < 20 && cyc < 400) begin
            out_ready = (cyc % 2 == 0);
            step();
            cyc++;
        end
        out_ready = 1'b1;
        step();
        check("stream_sent", sent, 20);
        check("stream_delivered", delivered, 20);
        check("stream_queue_empty", exp_q.size(), 0);

`ifdef ADDER_TREE_ACCUM_EN
        // Groups of four: 4 x 10 = 40, then 4 x 8 = 32 starting from zero
        mon_en  = 1'b0;
        acc_len = 8'd3;
        for (int g = 0; g < 2; g++) begin
            early = 0;
            for (int i = 0; i < 4; i++) begin
                in_valid = 1'b1;
                in_data  = (g == 0) ? vec10 : ones;
                step();
                if (out_valid) early++;
            end
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("acc_no_early", early, 0);
            check("acc_valid", out_valid, 1);
            check("acc_latency", lat, LAT);
            check("acc_sum", out_sum, (g == 0) ? 40 : 32);
            step();
            check("acc_single_pulse", out_valid, 0);
        end
        acc_len = '0;
        exp_q.delete();
        mon_en = 1'b1;
`endif

        // Reset mid-stream with vectors in flight
        mon_en    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = {8{64'(i + 1)}};
            step();
        end
        in_valid = 1'b0;
        check("rst_mid_pre_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async_valid", out_valid, 0);
        check("rst_mid_async_sum", out_sum, 0);
        step();
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_no_stale", out_valid, 0);
        end
        send_and_wait("post_reset", ones, 75'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
